watchdog_supervisor: RTL and testbench
======================================

// Module: watchdog_supervisor
// PURPOSE
//  Controller-side counterpart of the DAC watchdog link. Drives the periodic watchdog toggle to the peer board.
//  Checks that the peer echoes each toggle on reset_ack, and that its alive heartbeat keeps arriving.
//  On a fault it stops toggling, so the peer's watchdog resets its DACs. Optionally it also pulses instant_reset.
//  Sits in the PL next to the reset logic; cfg/sts are mapped to AXI GPIO registers.
// PARAMETERS
//  TOGGLE_CYCLES        1250000   half-period of watchdog_out (10 ms @125 MHz)
//  ACK_TIMEOUT_CYCLES   1250      max cycles from toggle to matching reset_ack; must be < TOGGLE_CYCLES
//  ALIVE_TIMEOUT_CYCLES 17500000  max cycles between alive rising edges (140 ms)
//  RESET_PULSE_CYCLES   125000    width of instant_reset_out pulse (1 ms)
//  CNT_WIDTH            26        width of all internal counters; must hold every *_CYCLES value
// PORTS
//  clk                in   1   system clock, 125 MHz
//  peripheral_areset  in   1   asynchronous reset, active-high
//  cfg                in   8   [0] enable, [1] auto instant-reset on fault, [7:2] reserved
//  clear_faults       in   1   single-cycle pulse: clear sticky faults, leave HALT
//  reset_ack_in       in   1   peer's echo of watchdog_out (asynchronous)
//  alive_in           in   1   peer's heartbeat (asynchronous)
//  watchdog_out       out  1   toggling watchdog to peer
//  instant_reset_out  out  1   instant reset request to peer
//  sts                out  32  status word, see below
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0; watchdog_out, instant_reset_out, faults and sts are 0.
//  reset_ack_in and alive_in pass through 2-FF synchronisers. The 2-cycle latency counts toward the timeouts.
//  States:
//   IDLE (00): watchdog_out held 0, counters cleared. cfg[0]=1 -> RUN.
//   RUN (01): tog_cnt counts 0..TOGGLE_CYCLES-1. On wrap, watchdog_out inverts and ack_pending is set.
//    - Ack check: ack_cnt starts at 0. A cycle with ack_sync==watchdog_out clears ack_pending.
//      If ack_cnt reaches ACK_TIMEOUT_CYCLES while still pending, ack_fault is set.
//    - Alive check: alive_cnt resets on a rising edge of alive_sync and saturates at ALIVE_TIMEOUT_CYCLES.
//      Reaching that value sets alive_fault. alive_cnt restarts at 0 on entry to RUN.
//    - On any fault: if cfg[1]=1 -> PULSE, else -> HALT.
//    - cfg[0]=0 with no fault -> IDLE. A fault in the same cycle takes priority.
//   PULSE (10): instant_reset_out=1 for exactly RESET_PULSE_CYCLES cycles, then -> HALT. cfg[0] is ignored.
//   HALT (11): watchdog_out frozen at its last value; no toggling. clear_faults -> IDLE.
//  Boundary cases:
//   - Fault and clear_faults in the same cycle: the set wins; the fault stays latched.
//   - clear_faults in RUN or PULSE clears no live fault and causes no state change.
//   - fault_cnt increments on each RUN->PULSE/HALT transition and saturates at 255.
//   - fault_cnt is cleared only by reset.
//   - Asynchronous reset mid-PULSE drops instant_reset_out immediately.
//  sts: [1:0] state, [2] watchdog_out, [3] ack_fault, [4] alive_fault, [5] instant_reset_out,
//       [6] alive_sync, [7] ack_sync, [15:8] fault_cnt, [31:16] 0.
//  All outputs are registered.
// TESTING  (TOGGLE=100, ACK_TIMEOUT=20, ALIVE_TIMEOUT=500, RESET_PULSE=10)
//  1. Peer model echoes the ack after 5 cycles and pulses alive every 300 cycles; cfg=0x01 for 5000 cycles
//     -> watchdog_out toggles every 100 cycles, no faults, sts[1:0]=01.
//  2. Echo withheld after the 3rd toggle
//     -> ack_fault=1 exactly 20 cycles after that toggle; state HALT; watchdog_out frozen; fault_cnt=1.
//  3. cfg=0x03, alive stopped -> 500 cycles after the last edge, alive_fault=1;
//     instant_reset_out high for exactly 10 cycles, then HALT.
//  4. In HALT, clear_faults pulse -> IDLE, faults 0, watchdog_out 0; with cfg[0]=1 still set, RUN on the next cycle.
//  5. clear_faults on the same cycle ack_fault sets -> ack_fault remains 1, state goes to HALT.
//  6. Assert peripheral_areset mid-PULSE -> all outputs 0 asynchronously; after release, the state is IDLE.

Source files
------------

// File: rtl/watchdog_supervisor_if.sv
// watchdog_supervisor_if: configuration/status and peer watchdog link of the supervisor
interface watchdog_supervisor_if;
   logic [7:0]  cfg;
   logic        clear_faults;
   logic        reset_ack_in;
   logic        alive_in;
   logic        watchdog_out;
   logic        instant_reset_out;
   logic [31:0] sts;
   modport master(output cfg, clear_faults, reset_ack_in, alive_in,
                  input watchdog_out, instant_reset_out, sts);
   modport slave(input cfg, clear_faults, reset_ack_in, alive_in,
                 output watchdog_out, instant_reset_out, sts);
endinterface

// File: rtl/watchdog_supervisor.sv
// watchdog_supervisor: drives the peer watchdog toggle, checks its echo and heartbeat, halts on fault
module watchdog_supervisor #(
   parameter int TOGGLE_CYCLES        = 1250000,
   parameter int ACK_TIMEOUT_CYCLES   = 1250,
   parameter int ALIVE_TIMEOUT_CYCLES = 17500000,
   parameter int RESET_PULSE_CYCLES   = 125000,
   parameter int CNT_WIDTH            = 26
) (
   input logic clk,
   input logic peripheral_areset,
   watchdog_supervisor_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PULSE = 2'b10, HALT = 2'b11} state_t;
   localparam logic [CNT_WIDTH-1:0] TOG_LAST   = CNT_WIDTH'(TOGGLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ACK_LAST   = CNT_WIDTH'(ACK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ALIVE_LAST = CNT_WIDTH'(ALIVE_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ALIVE_MAX  = CNT_WIDTH'(ALIVE_TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(RESET_PULSE_CYCLES - 1);
   state_t               state;
   logic [CNT_WIDTH-1:0] tog_cnt, ack_cnt, alive_cnt, pulse_cnt;
   logic [7:0]           fault_cnt;
   logic                 ack_s1, ack_sync, alive_s1, alive_sync, alive_prev;
   logic                 ack_pending, ack_fault, alive_fault, wd, ir;
   logic                 alive_rise, ack_to, alive_to;
   logic                 unused_cfg;
   assign unused_cfg = ^bus.cfg[7:2];
   // Timeouts fire on the cycle the counter would reach its limit, so the fault lands exactly on it
   always_comb begin
      alive_rise = alive_sync & ~alive_prev;
      ack_to     = ack_pending && (ack_sync != wd) && (ack_cnt == ACK_LAST);
      alive_to   = !alive_rise && (alive_cnt == ALIVE_LAST);
   end
   always_ff @(posedge clk or posedge peripheral_areset) begin
      if (peripheral_areset) begin
         state       <= IDLE;
         tog_cnt     <= '0;
         ack_cnt     <= '0;
         alive_cnt   <= '0;
         pulse_cnt   <= '0;
         fault_cnt   <= '0;
         ack_s1      <= 1'b0;
         ack_sync    <= 1'b0;
         alive_s1    <= 1'b0;
         alive_sync  <= 1'b0;
         alive_prev  <= 1'b0;
         ack_pending <= 1'b0;
         ack_fault   <= 1'b0;
         alive_fault <= 1'b0;
         wd          <= 1'b0;
         ir          <= 1'b0;
      end else begin
         {ack_sync, ack_s1}                <= {ack_s1, bus.reset_ack_in};
         {alive_prev, alive_sync, alive_s1} <= {alive_sync, alive_s1, bus.alive_in};
         case (state)
            IDLE: begin
               tog_cnt     <= '0;
               ack_cnt     <= '0;
               alive_cnt   <= '0;
               ack_pending <= 1'b0;
               wd          <= 1'b0;
               state       <= bus.cfg[0] ? RUN : IDLE;
            end
            RUN: begin
               if (ack_to || alive_to) begin
                  ack_fault   <= ack_to;
                  alive_fault <= alive_to;
                  fault_cnt   <= fault_cnt == 8'hff ? fault_cnt : fault_cnt + 8'd1;
                  pulse_cnt   <= '0;
                  ir          <= bus.cfg[1];
                  state       <= bus.cfg[1] ? PULSE : HALT;
               end else if (!bus.cfg[0]) begin
                  wd    <= 1'b0;
                  state <= IDLE;
               end else begin
                  tog_cnt   <= tog_cnt == TOG_LAST ? '0 : tog_cnt + 1'b1;
                  alive_cnt <= alive_rise ? '0 : alive_cnt == ALIVE_MAX ? alive_cnt : alive_cnt + 1'b1;
                  if (tog_cnt == TOG_LAST) begin
                     wd          <= ~wd;
                     ack_pending <= 1'b1;
                     ack_cnt     <= '0;
                  end else if (ack_pending) begin
                     ack_pending <= ack_sync != wd;
                     ack_cnt     <= ack_cnt + 1'b1;
                  end
               end
            end
            PULSE: begin
               pulse_cnt <= pulse_cnt + 1'b1;
               ir        <= pulse_cnt != PULSE_LAST;
               state     <= pulse_cnt == PULSE_LAST ? HALT : PULSE;
            end
            HALT: begin
               if (bus.clear_faults) begin
                  ack_fault   <= 1'b0;
                  alive_fault <= 1'b0;
                  wd          <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.watchdog_out      = wd;
   assign bus.instant_reset_out = ir;
   assign bus.sts = {16'h0000, fault_cnt, ack_sync, alive_sync, ir, alive_fault, ack_fault, wd, state};
endmodule

// File: tb/tb_watchdog_supervisor.sv
// tb_watchdog_supervisor: table, random-peer and hand-written corner checks of watchdog_supervisor
module tb_watchdog_supervisor;
   localparam int TOG = 100, ACKT = 20, ALVT = 500, PLS = 10, NEVER = 1 << 30;
   typedef struct {
      logic [7:0] cfg;
      int         d;
      int         gap;
      int         exp_off;
      logic [1:0] exp_flt;
      logic [1:0] exp_st;
   } vec_t;
   logic clk = 1'b0;
   logic peripheral_areset;
   int   cyc = 0;
   int   total = 0, bad = 0;
   int   dly[32];
   int   rise[$];
   vec_t tbl[7];
   watchdog_supervisor_if bus();
   watchdog_supervisor #(.TOGGLE_CYCLES(TOG), .ACK_TIMEOUT_CYCLES(ACKT), .ALIVE_TIMEOUT_CYCLES(ALVT),
      .RESET_PULSE_CYCLES(PLS), .CNT_WIDTH(16)) dut (.clk(clk), .peripheral_areset(peripheral_areset), .bus(bus));
   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #800000;
      $display("FAIL timeout: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, want);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      bus.cfg = 8'h00;
      bus.clear_faults = 1'b0;
      bus.reset_ack_in = 1'b0;
      bus.alive_in = 1'b0;
      peripheral_areset = 1'b1;
      repeat (3) tick;
      peripheral_areset = 1'b0;
      tick;
   endtask
   task automatic pulse_clear;
      bus.clear_faults = 1'b1;
      tick;
      bus.clear_faults = 1'b0;
   endtask
   task automatic wait_fault(input string name);
      int n = 0;
      while (bus.sts[4:3] == 2'b00 && n < 700) begin
         tick;
         n++;
      end
      chk(name, {31'b0, bus.sts[4:3] != 2'b00}, 32'd1);
   endtask
   // Peer echoes toggle j after dly[j] cycles and pulses alive at r+rise[i]; fault time derived from event times
   task automatic run_scn(input logic [7:0] cfg, input int win, output int f_off, output logic [31:0] last);
      int r, f, ack_f, alv_f, ref_e, tog_seen, ack_at, kk;
      logic ack_val, prev_wd, wd_e, ir_e;
      logic [1:0] st;
      logic [31:0] want;
      do_reset;
      bus.cfg = cfg;
      r = cyc + 1;
      ack_f = NEVER;
      for (int i = 31; i >= 1; i--) if (dly[i] + 3 > ACKT) ack_f = r + TOG * i + ACKT;
      alv_f = NEVER;
      ref_e = r;
      foreach (rise[i]) if (alv_f == NEVER) begin
         if (r + rise[i] + 3 - ref_e > ALVT) alv_f = ref_e + ALVT;
         else ref_e = r + rise[i] + 3;
      end
      if (alv_f == NEVER) alv_f = ref_e + ALVT;
      f = ack_f < alv_f ? ack_f : alv_f;
      prev_wd = 1'b0;
      tog_seen = 0;
      ack_at = -1;
      ack_val = 1'b0;
      f_off = -1;
      while (cyc < r + win && cyc < f + PLS + 15) begin
         tick;
         if (bus.watchdog_out !== prev_wd) begin
            prev_wd = bus.watchdog_out;
            tog_seen++;
            ack_at = cyc + dly[tog_seen > 31 ? 31 : tog_seen];
            ack_val = prev_wd;
         end
         if (cyc == ack_at) bus.reset_ack_in = ack_val;
         bus.alive_in = 1'b0;
         foreach (rise[i]) if (cyc - r - rise[i] inside {0, 1}) bus.alive_in = 1'b1;
         kk = (cyc < f ? cyc : f - 1) - r;
         wd_e = (kk / TOG) % 2 == 1;
         st = cyc < f ? 2'd1 : (cfg[1] && cyc < f + PLS) ? 2'd2 : 2'd3;
         ir_e = st == 2'd2;
         want = {16'h0, 8'(cyc >= f), 2'b00, ir_e, cyc >= f && alv_f == f, cyc >= f && ack_f == f, wd_e, st};
         chk("scn_sts", bus.sts & 32'hffff_ff3f, want);
         chk("scn_pins", {30'b0, bus.instant_reset_out, bus.watchdog_out}, {30'b0, ir_e, wd_e});
         if (f_off < 0 && bus.sts[4:3] != 2'b00) f_off = cyc - r;
      end
      last = bus.sts;
   endtask
   initial begin
      int f_off, o, r;
      logic [31:0] last;
      tbl[0] = '{8'h01, 5, 300, -1, 2'b00, 2'd1};
      tbl[1] = '{8'h01, 17, 500, -1, 2'b00, 2'd1};
      tbl[2] = '{8'h01, 18, 300, 120, 2'b01, 2'd3};
      tbl[3] = '{8'h01, 5, 501, 500, 2'b10, 2'd3};
      tbl[4] = '{8'h03, 5, 501, 500, 2'b10, 2'd3};
      tbl[5] = '{8'h03, 30, 300, 120, 2'b01, 2'd3};
      tbl[6] = '{8'h01, 18, 501, 120, 2'b01, 2'd3};
      do_reset;
      chk("reset_sts", bus.sts, 32'h0);
      chk("reset_pins", {30'b0, bus.instant_reset_out, bus.watchdog_out}, 32'h0);
      for (int t = 0; t < 7; t++) begin
         foreach (dly[i]) dly[i] = tbl[t].d;
         rise.delete();
         for (int g = tbl[t].gap - 3; g < 1500; g += tbl[t].gap) rise.push_back(g);
         run_scn(tbl[t].cfg, 700, f_off, last);
         chk("tbl_fault_time", f_off, tbl[t].exp_off);
         chk("tbl_faults", {30'b0, last[4:3]}, {30'b0, tbl[t].exp_flt});
         chk("tbl_state", {30'b0, last[1:0]}, {30'b0, tbl[t].exp_st});
      end
      for (int n = 0; n < 6; n++) begin
         foreach (dly[i]) dly[i] = $urandom_range(0, 9) == 0 ? int'($urandom_range(18, 40)) : int'($urandom_range(1, 17));
         rise.delete();
         o = -3;
         while (o < 1500) begin
            o += int'($urandom_range(150, 530));
            rise.push_back(o);
         end
         run_scn({6'b0, 1'($urandom_range(0, 1)), 1'b1}, 1600, f_off, last);
      end
      // clear_faults in RUN is ignored; HALT freezes watchdog; clear returns to IDLE then RUN
      do_reset;
      bus.cfg = 8'h01;
      r = cyc + 1;
      repeat (5) tick;
      pulse_clear;
      chk("clear_in_run", {27'b0, bus.sts[4:3], bus.sts[2], bus.sts[1:0]}, 32'h1);
      wait_fault("h1_fault_seen");
      chk("h1_fault_time", cyc - r, 120);
      chk("h1_halt", {27'b0, bus.sts[4:0]}, 32'b01111);
      repeat (150) tick;
      chk("h1_frozen", {30'b0, bus.watchdog_out, bus.sts[2]}, 32'b11);
      chk("h1_fault_cnt", {24'b0, bus.sts[15:8]}, 32'd1);
      pulse_clear;
      chk("h1_clear_idle", {26'b0, bus.sts[5:0]}, 32'h0);
      tick;
      chk("h1_rerun", {30'b0, bus.sts[1:0]}, 32'd1);
      wait_fault("h1_second_fault");
      chk("h1_fault_cnt2", {24'b0, bus.sts[15:8]}, 32'd2);
      // clear_faults on the very cycle ack_fault sets
      do_reset;
      bus.cfg = 8'h01;
      r = cyc + 1;
      while (cyc < r + 119) begin
         tick;
         if (cyc == r + 99) chk("h2_pre_toggle", {31'b0, bus.watchdog_out}, 32'd0);
         if (cyc == r + 100) chk("h2_toggle", {31'b0, bus.watchdog_out}, 32'd1);
      end
      chk("h2_pre_fault", {31'b0, bus.sts[3]}, 32'd0);
      pulse_clear;
      chk("h2_set_wins", {29'b0, bus.sts[3], bus.sts[1:0]}, 32'b111);
      // asynchronous reset in the middle of the instant-reset pulse
      do_reset;
      bus.cfg = 8'h03;
      r = cyc + 1;
      while (cyc < r + 125) tick;
      chk("h3_pulse", {29'b0, bus.instant_reset_out, bus.sts[1:0]}, 32'b110);
      #2;
      peripheral_areset = 1'b1;
      #1;
      chk("h3_async_sts", bus.sts, 32'h0);
      chk("h3_async_pins", {30'b0, bus.instant_reset_out, bus.watchdog_out}, 32'h0);
      bus.cfg = 8'h00;
      repeat (2) tick;
      peripheral_areset = 1'b0;
      tick;
      chk("h3_idle", bus.sts, 32'h0);
      // fault counter saturation, cleared only by reset
      do_reset;
      bus.cfg = 8'h01;
      for (int n = 0; n < 257; n++) begin
         wait_fault("h4_fault_seen");
         pulse_clear;
      end
      chk("h4_saturate", {24'b0, bus.sts[15:8]}, 32'd255);
      do_reset;
      chk("h4_reset_cnt", {24'b0, bus.sts[15:8]}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
